// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: one write port, two read ports, clear handshake.
// The regfile side uses the slave modport; decode/writeback drive through master.
interface regfile_param_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              clr_req;
    logic              busy;
    logic              wr_drop;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output clr_req,
        input  rd_data_a, rd_data_b, busy, wr_drop
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  clr_req,
        output rd_data_a, rd_data_b, busy, wr_drop
    );
endinterface

// File: rtl/regfile_param.sv
// 2-read/1-write register file with registered write-first reads and a sequential bulk clear.
// Optional macro REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
//
// state   | meaning
// IDLE    | normal operation, writes commit
// CLEAR   | zeroing mem[ptr] each cycle, writes dropped, busy high
module regfile_param #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input logic           clk,
    input logic           rst_n,
    regfile_param_if.slave bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;
    logic              drop_q, drop_d;

    logic wr_in_range;
    logic wr_ok;
    logic wr_commit;
    logic clearing;

    assign clearing    = (state_q == S_CLEAR);
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_X);
`ifdef REGFILE_ZERO_REG_EN
    assign wr_ok       = wr_in_range && (bus.wr_addr != '0);
`else
    assign wr_ok       = wr_in_range;
`endif
    assign wr_commit   = bus.wr_en && wr_ok && (state_q == S_IDLE);

    // Priority: clear of the current entry beats write bypass beats stored value.
    function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] v;
        v = ({1'b0, a} < DEPTH_X) ? stored : '0;
        if (wr_commit && (a == bus.wr_addr)) v = bus.wr_data;
        if (clearing && (a == ptr_q)) v = '0;
`ifdef REGFILE_ZERO_REG_EN
        if (a == '0) v = '0;
`endif
        return v;
    endfunction

    always_comb begin
        mem_d   = mem_q;
        state_d = state_q;
        ptr_d   = ptr_q;
        drop_d  = 1'b0;
        rd_a_d  = rd_a_q;
        rd_b_d  = rd_b_q;

        case (state_q)
            S_IDLE: begin
                if (bus.clr_req) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + 1'b1;
                drop_d       = bus.wr_en && wr_ok;
                if (ptr_q == LAST_PTR) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_commit) mem_d[bus.wr_addr] = bus.wr_data;
`ifdef REGFILE_ZERO_REG_EN
        mem_d[0] = '0;
`endif

        if (bus.rd_en_a) rd_a_d = rd_sel(bus.rd_addr_a, mem_q[bus.rd_addr_a]);
        if (bus.rd_en_b) rd_b_d = rd_sel(bus.rd_addr_b, mem_q[bus.rd_addr_b]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.rd_data_a = rd_a_q;
    assign bus.rd_data_b = rd_b_q;
    assign bus.busy      = clearing;
    assign bus.wr_drop   = drop_q;

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised 2-read/1-write register file; successor to the fixed 16x20 register file in the datapath.
- Generalised in data width and depth.
- Adds asynchronous reset, registered reads with write-first bypass, and a sequential bulk-clear engine with a busy handshake.
- Sits between the decode stage (read addresses) and the writeback stage (write port).

Parameters:
- DATA_W, 20, width of each entry in bits.
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of entries; must satisfy 2 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rd_en_a  input  1  read enable, port A.
- rd_addr_a  input  ADDR_W  read address, port A.
- rd_data_a  output  DATA_W  registered read data, port A.
- rd_en_b  input  1  read enable, port B.
- rd_addr_b  input  ADDR_W  read address, port B.
- rd_data_b  output  DATA_W  registered read data, port B.
- clr_req  input  1  single-cycle request to zero all entries.
- busy  output  1  high while the clear engine runs.
- wr_drop  output  1  one-cycle pulse when a write is discarded.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entries, rd_data_a and rd_data_b are 0.
  - busy=0, wr_drop=0, FSM=IDLE, clear pointer=0.
  - Release is synchronous to the next clk edge.
- Write:
  - Occurs when wr_en=1, busy=0 and wr_addr<DEPTH: mem[wr_addr] <= wr_data at the rising edge.
  - wr_addr>=DEPTH: write ignored, no wr_drop.
- Read (per port, independent):
  - Latency 1. If rd_en_x=1 at edge N, rd_data_x after edge N holds mem[rd_addr_x] as of before edge N.
  - rd_en_x=0: rd_data_x holds its previous value.
  - rd_addr_x>=DEPTH: returns 0.
  - Both ports may read the same address in the same cycle.
- Bypass (write-first):
  - If a write commits at edge N to the address a port reads at edge N, that port returns wr_data.
  - Applies to A and B independently.
- Clear FSM, states IDLE and CLEAR:
  - IDLE, clr_req=1: go to CLEAR, ptr<=0. busy rises after the same edge.
  - CLEAR, each cycle: mem[ptr]<=0, ptr<=ptr+1.
  - When ptr==DEPTH-1, that entry is cleared and the FSM returns to IDLE; busy falls after that edge.
  - busy is high for exactly DEPTH cycles.
  - clr_req while in CLEAR is ignored (not queued).
- During CLEAR:
  - Writes are discarded. wr_drop pulses high for the cycle after each discarded write.
  - Reads continue and return current contents, so a partially cleared array is visible.
  - A read of mem[ptr] at the edge that clears it returns 0 (clear has bypass priority).
- clr_req and wr_en together in IDLE: the write commits, then CLEAR begins. The written entry ends at 0.
- rst_n low mid-clear: immediate return to IDLE, array zero, busy=0.
- wr_drop is registered. It never asserts outside CLEAR, or in the cycle busy rises.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired to 0; writes to address 0 are silently ignored, with no wr_drop.
  - Reads of address 0 return 0, including under bypass.
  - The clear engine still sweeps all DEPTH entries, so timing is unchanged.
- Undefined: entry 0 behaves as an ordinary storage entry.

Test Plan:
- Reset then read all addresses on A and B -> every rd_data = 0x00000, busy=0.
- Write 0xABCDE to addr 5, next cycle rd_en_a=1 rd_addr_a=5 -> rd_data_a=0xABCDE one cycle later; rd_data_b unchanged while rd_en_b=0.
- Same-edge write 0x12345 to addr 9 with rd_addr_a=rd_addr_b=9 -> both ports return 0x12345 (bypass), not the old value.
- Fill all 16 entries, pulse clr_req -> busy high exactly 16 cycles. A write to addr 3 in cycle 4 of CLEAR -> wr_drop pulse, addr 3 = 0 afterwards. All entries read 0 once busy falls.
- Start clear, assert rst_n low at clear cycle 7 -> busy=0 immediately, all outputs 0. Normal write/read to addr 15 works after release.
- With REGFILE_ZERO_REG_EN defined, write 0xFFFFF to addr 0 with same-edge read of addr 0 -> rd_data=0, no wr_drop. Without the macro -> 0xFFFFF.
